// File: rtl/upload_frame_encoder.sv
// rtl/upload_frame_encoder.sv - buffers source-tagged upload bytes and emits SOF/src/len/payload frames
// Define UPLOAD_FRAME_CHECKSUM_EN to append the modulo-256 checksum byte (CSUM state).
module upload_frame_encoder #(
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  SOF0    = 8'hAA,
  parameter logic [7:0]  SOF1    = 8'h44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] usb_upload_data,
  output logic       usb_upload_valid,
  input  logic       usb_upload_ready,
  output logic       busy
);
  localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_CNT = 8'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE, COLLECT, SOF_A, SOF_B, SRC, LEN_H, LEN_L, PAYLOAD, CSUM
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] src_q, src_d;
  logic [7:0] rd_idx_q, rd_idx_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  logic [7:0] buf_mem [MAX_LEN];
  logic [7:0] nxt_idx;
  logic       src_switch, accept, collect_end, out_fire;

  // A byte from a new source closes the frame without being consumed.
  assign src_switch   = upload_valid && (count_q != 8'd0) && (upload_source != src_q);
  assign upload_ready = (state_q == COLLECT) && (count_q < MAX_CNT) && upload_req && !src_switch;
  assign accept       = upload_ready && upload_valid;
  assign collect_end  = !upload_req || (count_q == MAX_CNT) || src_switch;
  assign out_fire     = valid_q && usb_upload_ready;
  assign nxt_idx      = rd_idx_q + 8'd1;

  assign usb_upload_data  = data_q;
  assign usb_upload_valid = valid_q;
  assign busy             = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    src_d    = src_q;
    rd_idx_d = rd_idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (upload_req) begin
          state_d = COLLECT;
          count_d = 8'd0;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count_q == 8'd0) src_d = upload_source;
          count_d = count_q + 8'd1;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
          csum_d  = csum_q + upload_data;
`endif
        end else if (collect_end) begin
          if (count_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            state_d = SOF_A;
            valid_d = 1'b1;
            data_d  = SOF0;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
            csum_d  = csum_q + src_q + count_q;
`endif
          end
        end
      end
      SOF_A: if (out_fire) begin state_d = SOF_B; data_d = SOF1; end
      SOF_B: if (out_fire) begin state_d = SRC; data_d = src_q; end
      SRC:   if (out_fire) begin state_d = LEN_H; data_d = 8'h00; end
      LEN_H: if (out_fire) begin state_d = LEN_L; data_d = count_q; end
      LEN_L: begin
        if (out_fire) begin
          state_d  = PAYLOAD;
          rd_idx_d = 8'd0;
          data_d   = buf_mem[0];
        end
      end
      PAYLOAD: begin
        if (out_fire) begin
          if (nxt_idx == count_q) begin
`ifdef UPLOAD_FRAME_CHECKSUM_EN
            state_d = CSUM;
            data_d  = csum_q;
`else
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = 8'h00;
`endif
          end else begin
            rd_idx_d = nxt_idx;
            data_d   = buf_mem[nxt_idx[AW-1:0]];
          end
        end
      end
`ifdef UPLOAD_FRAME_CHECKSUM_EN
      CSUM: begin
        if (out_fire) begin
          state_d = IDLE;
          valid_d = 1'b0;
          data_d  = 8'h00;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      src_q    <= 8'd0;
      rd_idx_q <= 8'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      src_q    <= src_d;
      rd_idx_q <= rd_idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef UPLOAD_FRAME_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Payload storage needs no reset; only bytes below count are ever read.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[count_q[AW-1:0]] <= upload_data;
  end
endmodule

// File: tb/tb_upload_frame_encoder.sv
// tb/tb_upload_frame_encoder.sv - scoreboard bench for upload_frame_encoder
module tb_upload_frame_encoder;
  localparam int MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       upload_req;
  logic [7:0] upload_data;
  logic [7:0] upload_source;
  logic       upload_valid;
  logic       upload_ready;
  logic [7:0] usb_upload_data;
  logic       usb_upload_valid;
  logic       usb_upload_ready;
  logic       busy;

  always #5 clk = ~clk;

  upload_frame_encoder #(.MAX_LEN(MAX_LEN), .SOF0(8'hAA), .SOF1(8'h44)) dut (
    .clk(clk), .rst(rst),
    .upload_req(upload_req), .upload_data(upload_data), .upload_source(upload_source),
    .upload_valid(upload_valid), .upload_ready(upload_ready),
    .usb_upload_data(usb_upload_data), .usb_upload_valid(usb_upload_valid),
    .usb_upload_ready(usb_upload_ready), .busy(busy)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] bsrc[$];
  logic [7:0] bdat[$];
  bit         mon_ignore = 0;
  int         ignore_hs = 0;
  int         sink_mode = 0;
  bit         gaps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Reference: split a burst into runs of one source, each cut into MAX_LEN-byte frames.
  task automatic push_expected();
    int i = 0;
    int n = bsrc.size();
    while (i < n) begin
      logic [7:0] s;
      logic [7:0] pl[$];
      int sum;
      s = bsrc[i];
      pl = {};
      while (i < n && bsrc[i] == s && pl.size() < MAX_LEN) begin
        pl.push_back(bdat[i]);
        i++;
      end
      sum = int'(s) + pl.size();
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h44);
      exp_q.push_back(s);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(pl.size()));
      foreach (pl[k]) begin
        exp_q.push_back(pl[k]);
        sum += int'(pl[k]);
      end
`ifdef UPLOAD_FRAME_CHECKSUM_EN
      exp_q.push_back(8'(sum % 256));
`endif
    end
  endtask

  task automatic drive_bytes();
    bit acc;
    int to;
    upload_req = 1'b1;
    for (int i = 0; i < bsrc.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        upload_valid = 1'b0;
        @(posedge clk); #1;
      end
      upload_valid  = 1'b1;
      upload_source = bsrc[i];
      upload_data   = bdat[i];
      to = 0;
      forever begin
        @(negedge clk);
        acc = upload_ready;
        @(posedge clk); #1;
        if (acc) break;
        to++;
        if (to > 500) begin
          fail("accept_timeout");
          break;
        end
      end
    end
    upload_valid = 1'b0;
    upload_req   = 1'b0;
  endtask

  task automatic wait_idle();
    int to = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 3000) fail("drain_timeout");
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_frames", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_burst();
    push_expected();
    drive_bytes();
    wait_idle();
  endtask

  initial begin : sink
    int ph = 0;
    usb_upload_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0:       usb_upload_ready = 1'b1;
        1:       begin usb_upload_ready = (ph % 3 == 0); ph++; end
        default: usb_upload_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin : monitor
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_stall && !rst) begin
        check("stall_hold_valid", usb_upload_valid, 1'b1);
        check("stall_hold_data", usb_upload_data, prev_data);
      end
      if (usb_upload_valid && usb_upload_ready) begin
        if (mon_ignore) begin
          ignore_hs++;
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", usb_upload_data);
        end else begin
          check("frame_byte", usb_upload_data, exp_q.pop_front());
        end
      end
      prev_stall = usb_upload_valid && !usb_upload_ready;
      prev_data  = usb_upload_data;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int to;
    rst = 1'b1;
    upload_req = 1'b0;
    upload_valid = 1'b0;
    upload_data = 8'h00;
    upload_source = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_usb_valid", usb_upload_valid, 1'b0);
    check("rst_usb_data", usb_upload_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_upload_ready", upload_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic burst, overflow split, source switch
    bsrc = '{8'h01, 8'h01, 8'h01};
    bdat = '{8'h11, 8'h22, 8'h33};
    run_burst();
    bsrc = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    bdat = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    run_burst();
    bsrc = '{8'h01, 8'h01, 8'h03};
    bdat = '{8'hA0, 8'hA1, 8'hB0};
    run_burst();

    // sink stalls 1,0,0 pattern
    sink_mode = 1;
    bsrc = '{8'h01, 8'h01, 8'h01};
    bdat = '{8'h11, 8'h22, 8'h33};
    run_burst();
    sink_mode = 0;
    @(posedge clk); #1;

    // empty request pulse: nothing may come out
    upload_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 upload_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("empty_no_busy", busy, 1'b0);
    check("empty_no_valid", usb_upload_valid, 1'b0);
    @(posedge clk); #1;

    // reset right after the second payload byte is handed over
    mon_ignore = 1;
    ignore_hs = 0;
    bsrc = '{8'h07, 8'h07, 8'h07};
    bdat = '{8'h01, 8'h02, 8'h03};
    drive_bytes();
    to = 0;
    while (ignore_hs < 7 && to < 200) begin
      @(posedge clk);
      to++;
    end
    if (to >= 200) fail("reset_test_timeout");
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_usb_valid", usb_upload_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", usb_upload_data, 8'h00);
    mon_ignore = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // randomized bursts with input gaps and random sink backpressure
    sink_mode = 2;
    gaps = 1;
    for (int b = 0; b < 30; b++) begin
      int len;
      logic [7:0] s;
      len = $urandom_range(1, 10);
      s = 8'($urandom_range(1, 3));
      bsrc = {};
      bdat = {};
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(1, 3));
        bsrc.push_back(s);
        bdat.push_back(8'($urandom_range(0, 255)));
      end
      run_burst();
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/upload_frame_encoder.md
UPLOAD_FRAME_ENCODER -- requirements
Module: upload_frame_encoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning maximum payload bytes per frame (range 1..255).
REQ-002 SHALL have parameter SOF0, default 8'hAA, meaning first start-of-frame byte.
REQ-003 SHALL have parameter SOF1, default 8'h44, meaning second start-of-frame byte.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port upload_req, input, 1, handler requests a frame; high for the whole burst.
REQ-007 SHALL have port upload_data, input, 8, payload byte.
REQ-008 SHALL have port upload_source, input, 8, source ID of the payload byte.
REQ-009 SHALL have port upload_valid, input, 1, upload_data/upload_source are valid.
REQ-010 SHALL have port upload_ready, output, 1, byte accepted when upload_valid && upload_ready.
REQ-011 SHALL have port usb_upload_data, output, 8, framed output byte.
REQ-012 SHALL have port usb_upload_valid, output, 1, usb_upload_data is valid.
REQ-013 SHALL have port usb_upload_ready, input, 1, sink accepts the byte when usb_upload_valid && usb_upload_ready.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL use states IDLE, COLLECT, SOF_A, SOF_B, SRC, LEN_H, LEN_L, PAYLOAD, CSUM.
REQ-016 IDLE -> COLLECT on upload_req=1; upload_ready=1 only in COLLECT when count<MAX_LEN.
REQ-017 The first accepted byte SHALL latch upload_source; each accepted byte is written to an internal MAX_LEN-deep buffer, and count is incremented.
REQ-018 COLLECT SHALL end when upload_req=0, when count reaches MAX_LEN, or when upload_valid=1 with a source different from the latched source.
- In the last case, the byte SHALL NOT be accepted: upload_ready=0 in that cycle.
REQ-019 On end with count=0, the state SHALL return to IDLE and no frame is emitted.
- Otherwise the state SHALL go to SOF_A; usb_upload_valid SHALL assert in the next cycle.
REQ-020 The frame SHALL be, in order: SOF0, SOF1, source, 8'h00, count[7:0], payload bytes in acceptance order, checksum.
REQ-021 Each state SHALL advance only on usb_upload_valid && usb_upload_ready; usb_upload_data SHALL stay stable while stalled.
REQ-022 The checksum SHALL be the 8-bit modulo-256 sum of source, both length bytes and all payload bytes; SOF bytes are excluded.
REQ-023 After the final byte is accepted, the state SHALL go to IDLE; upload_ready SHALL stay 0 from end of COLLECT until IDLE.
REQ-024 If upload_req is still 1 on return to IDLE, a new collection SHALL start the next cycle (back-to-back frames).
REQ-025 upload_valid SHALL be ignored outside COLLECT; upload_req rising during transmit SHALL be held off, not lost.
REQ-026 Payload, count, source and checksum registers SHALL be exact-width and wrap silently; count never exceeds MAX_LEN.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, count=0, checksum=0, upload_ready=0, usb_upload_valid=0, usb_upload_data=8'h00, busy=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; no further bytes of that frame are emitted.

Configuration
REQ-029 Macro UPLOAD_FRAME_CHECKSUM_EN defined: the CSUM state and trailing checksum byte SHALL be present.
- Undefined: the frame SHALL end after the last payload byte (PAYLOAD -> IDLE), and the checksum logic SHALL be absent.

Verification
REQ-030 Burst: source 8'h01, bytes 11,22,33, upload_req then drops; usb_upload_ready=1 -> output AA 44 01 00 03 11 22 33 6A, with no gaps.
REQ-031 Overflow: MAX_LEN=4, 6 bytes with req held -> upload_ready=0 after byte 4; frame with LEN_L=04; the remaining 2 bytes go in a second frame with LEN_L=02.
REQ-032 Source switch: bytes 01:A0, 01:A1, 03:B0 -> frame src 01 len 2, then frame src 03 len 1; B0 is not lost.
REQ-033 Backpressure: usb_upload_ready toggles 1,0,0,1... -> data is held during stalls; the byte sequence is identical to REQ-030.
REQ-034 Empty/reset: req pulse with no valid -> no output; rst asserted after 2 payload bytes are sent -> usb_upload_valid=0 the next cycle, state IDLE.
REQ-035 Macro undefined: the REQ-030 stimulus -> AA 44 01 00 03 11 22 33, then IDLE.
